// File: rtl/ipbase_fifo_sync_v2.sv
// Synchronous single-clock FIFO with FWFT or standard read mode, flush,
// exact occupancy count, almost/programmable flags and per-cycle status pulses.
module ipbase_fifo_sync_v2 #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned FIFO_DEPTH        = 2048,
  parameter string       READ_MODE         = "fwft",
  parameter int unsigned PROG_FULL_THRESH  = FIFO_DEPTH - 48,
  parameter int unsigned PROG_EMPTY_THRESH = 10,
  localparam int unsigned CNT_WIDTH        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  prog_empty,
  output logic                  prog_full,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam bit          FWFT  = (READ_MODE == "fwft");

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_PF   = CNT_WIDTH'(PROG_FULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_PE   = CNT_WIDTH'(PROG_EMPTY_THRESH);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;

  always_comb begin
    wr_acc     = wr_en & ~full  & ~flush;
    rd_acc     = rd_en & ~empty & ~flush;
    count_nxt  = data_count;
    if (flush)
      count_nxt = '0;
    else if (wr_acc && !rd_acc)
      count_nxt = data_count + CNT_ONE;
    else if (rd_acc && !wr_acc)
      count_nxt = data_count - CNT_ONE;
    rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    // When the FIFO drains to nothing before this write lands, the written
    // word becomes the new head and is not yet in the array.
    if (wr_acc && ((data_count == '0) || (rd_acc && data_count == CNT_ONE)))
      head_nxt = din;
    else
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge wr_clk) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      prog_empty   <= 1'b1;
      prog_full    <= 1'b0;
      dout         <= '0;
      data_valid   <= 1'b0;
      wr_ack       <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr + PTR_ONE;
        rd_ptr <= rd_ptr_nxt;
      end

      data_count   <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CNT_FULL);
      almost_empty <= (count_nxt <= CNT_ONE);
      almost_full  <= (count_nxt >= CNT_AF);
      prog_empty   <= (count_nxt <= CNT_PE);
      prog_full    <= (count_nxt >= CNT_PF);

      wr_ack    <= wr_acc;
      overflow  <= wr_en & full  & ~flush;
      underflow <= rd_en & empty & ~flush;

      if (flush) begin
        data_valid <= 1'b0;
      end else if (FWFT) begin
        data_valid <= (count_nxt != '0);
        if (count_nxt != '0)
          dout <= head_nxt;
      end else begin
        data_valid <= rd_acc;
        if (rd_acc)
          dout <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_ipbase_fifo_sync_v2.sv
// Drives an FWFT and a standard-mode FIFO with identical stimulus and checks
// both every cycle against a queue-based reference model.
module tb_ipbase_fifo_sync_v2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] din;

  logic [15:0] f_dout, s_dout;
  logic        f_dv, f_empty, f_full, f_ae, f_af, f_pe, f_pf, f_ack, f_ov, f_un;
  logic        s_dv, s_empty, s_full, s_ae, s_af, s_pe, s_pf, s_ack, s_ov, s_un;
  logic [4:0]  f_count, s_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_fdout, m_sdout;
  logic        m_fdv, m_sdv, m_ack, m_ov, m_un;

  ipbase_fifo_sync_v2 #(
    .DATA_WIDTH(16), .FIFO_DEPTH(16), .READ_MODE("fwft"),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
  ) u_fwft (
    .wr_clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(f_dout), .data_valid(f_dv), .empty(f_empty),
    .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .prog_empty(f_pe), .prog_full(f_pf), .data_count(f_count),
    .wr_ack(f_ack), .overflow(f_ov), .underflow(f_un)
  );

  ipbase_fifo_sync_v2 #(
    .DATA_WIDTH(16), .FIFO_DEPTH(16), .READ_MODE("std"),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
  ) u_std (
    .wr_clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(s_dout), .data_valid(s_dv), .empty(s_empty),
    .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .prog_empty(s_pe), .prog_full(s_pf), .data_count(s_count),
    .wr_ack(s_ack), .overflow(s_ov), .underflow(s_un)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fdout = '0; m_sdout = '0;
    m_fdv = 1'b0; m_sdv = 1'b0;
    m_ack = 1'b0; m_ov = 1'b0; m_un = 1'b0;
  endtask

  task automatic model_edge(input logic f, input logic w, input logic r, input logic [15:0] d);
    int  n;
    logic wa, ra;
    n = m_q.size();
    if (f) begin
      m_q.delete();
      m_ack = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      m_fdv = 1'b0; m_sdv = 1'b0;
    end else begin
      wa = w && (n < 16);
      ra = r && (n > 0);
      m_ack = wa;
      m_ov  = w && !wa;
      m_un  = r && !ra;
      m_sdv = ra;
      if (ra) begin
        m_sdout = m_q[0];
        void'(m_q.pop_front());
      end
      if (wa) m_q.push_back(d);
      if (m_q.size() > 0) begin
        m_fdout = m_q[0];
        m_fdv   = 1'b1;
      end else begin
        m_fdv = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int         n;
    logic [5:0] fl;
    logic [2:0] pl;
    n  = m_q.size();
    fl = {n == 0, n == 16, n <= 1, n >= 15, n <= 3, n >= 12};
    pl = {m_ack, m_ov, m_un};
    chk("f_count", 32'(f_count), 32'(n));
    chk("f_flags", 32'({f_empty, f_full, f_ae, f_af, f_pe, f_pf}), 32'(fl));
    chk("f_pulses", 32'({f_ack, f_ov, f_un}), 32'(pl));
    chk("f_valid", 32'(f_dv), 32'(m_fdv));
    chk("f_dout", 32'(f_dout), 32'(m_fdout));
    chk("s_count", 32'(s_count), 32'(n));
    chk("s_flags", 32'({s_empty, s_full, s_ae, s_af, s_pe, s_pf}), 32'(fl));
    chk("s_pulses", 32'({s_ack, s_ov, s_un}), 32'(pl));
    chk("s_valid", 32'(s_dv), 32'(m_sdv));
    chk("s_dout", 32'(s_dout), 32'(m_sdout));
  endtask

  task automatic step(input logic f, input logic w, input logic r, input logic [15:0] d);
    flush = f; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    model_edge(f, w, r, d);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill to full, then overflow attempt
    for (int i = 1; i <= 16; i++) step(0, 1, 0, 16'(i));
    chk("fill_full", 32'(f_full), 32'd1);
    chk("fill_count", 32'(f_count), 32'd16);
    step(0, 1, 0, 16'h0011);
    chk("fill_overflow", 32'(f_ov), 32'd1);

    // Simultaneous read/write at full: read wins, write rejected
    step(0, 1, 1, 16'h0099);
    chk("full_rw_ovf", 32'(s_ov), 32'd1);

    // Drain, then read on empty
    for (int i = 0; i < 15; i++) step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    chk("empty_underflow", 32'(f_un), 32'd1);

    // Simultaneous at empty: write accepted, read rejected
    step(0, 1, 1, 16'h1234);
    chk("empty_rw_count", 32'(f_count), 32'd1);

    // Simultaneous at count 5: no change, no pulses
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'($urandom));
    step(0, 1, 1, 16'h4321);
    chk("mid_rw_count", 32'(f_count), 32'd5);

    // Standard-mode read latency
    step(1, 0, 0, 16'h0);
    step(0, 1, 0, 16'hA5A5);
    step(0, 1, 0, 16'h5A5A);
    step(0, 0, 1, 16'h0);
    chk("std_lat_dout", 32'(s_dout), 32'hA5A5);
    chk("std_lat_valid", 32'(s_dv), 32'd1);
    step(0, 0, 0, 16'h0);
    chk("std_idle_valid", 32'(s_dv), 32'd0);

    // Wrap pointers many times at occupancy 7
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 16'($urandom));
    for (int i = 0; i < 40; i++) step(0, 1, 1, 16'($urandom));

    // Flush at count 9 with a concurrent write
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 16'($urandom));
    step(1, 1, 0, 16'hDEAD);
    chk("flush_noack", 32'(f_ack), 32'd0);
    chk("flush_empty", 32'(f_empty), 32'd1);

    // Refill to 5, then asynchronous reset in the middle of a cycle
    for (int i = 0; i < 5; i++) step(0, 1, 0, 16'($urandom));
    wr_en = 1'b1; din = 16'h7777;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    step(0, 1, 0, 16'hBEEF);
    chk("post_reset_ack", 32'(f_ack), 32'd1);

    // Randomised traffic with varying write/read bias
    for (int p = 0; p < 4; p++) begin
      int pw, pr;
      pw = (p == 0) ? 80 : (p == 1) ? 20 : 50;
      pr = (p == 0) ? 20 : (p == 1) ? 80 : 50;
      for (int i = 0; i < 400; i++)
        step($urandom_range(199) == 0, $urandom_range(99) < pw,
             $urandom_range(99) < pr, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
